// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage and its helpers.
//   - bus widths for the stall vector and instruction address bus
//   - exception bit index for an instruction-fetch address error
//   - kseg0/kseg1 segment tags used by the virtual-to-physical mapper
//   - NOP encoding and the IF/ID hold-buffer state encoding
package if_fetch_stage_pkg;

    localparam int unsigned STALL_W       = 6;
    localparam int unsigned INST_ADDR_W   = 32;
    localparam int unsigned EXC_W         = 32;

    localparam int unsigned EXC_ADEL_BIT_DEF = 4;

    localparam logic [2:0] SEG_KSEG0 = 3'b100;
    localparam logic [2:0] SEG_KSEG1 = 3'b101;

    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;

    // Hold-buffer states: EMPTY shows a bubble, RUN passes SRAM data through,
    // HOLD replays the word captured when decode stalled.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_HOLD  = 2'b10;

    // A fetch address must be word aligned.
    function automatic logic is_misaligned(input logic [INST_ADDR_W-1:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/if_fetch_stage_addr_map.sv
// if_addr_map: combinational virtual-to-physical address mapper.
//   vaddr in  32  virtual address
//   paddr out 32  physical address; kseg0/kseg1 drop their top three bits,
//                 every other segment passes through unchanged.
module if_addr_map
    import if_fetch_stage_pkg::*;
(
    input  logic [INST_ADDR_W-1:0] vaddr,
    output logic [INST_ADDR_W-1:0] paddr
);

    // Unmapped kernel segments alias the low 512 MB of physical space.
    always_comb begin
        paddr = vaddr;
        if ((vaddr[31:29] == SEG_KSEG0) || (vaddr[31:29] == SEG_KSEG1)) begin
            paddr = {3'b000, vaddr[28:0]};
        end else begin
            paddr = vaddr;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage between the PC register and decode.
//   clk, rst             clock, asynchronous active-low reset
//   stall[5:0]           pipeline stall vector (bit1 = IF, bit2 = ID)
//   flush                exception/eret flush of the IF/ID contents
//   pc, ce               fetch PC and its valid strobe
//   inst_sram_*          instruction SRAM port (read-only use)
//   id_pc, id_inst       PC and instruction word presented to decode
//   id_valid             IF/ID holds a real instruction
//   id_excepttype        exception vector accompanying id_pc
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'hbfc0_0000,
    parameter int unsigned EXC_ADEL_BIT = EXC_ADEL_BIT_DEF,
    parameter logic [31:0] NOP_INST     = NOP_INST_DEF
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [STALL_W-1:0]     stall,
    input  logic                   flush,
    input  logic [INST_ADDR_W-1:0] pc,
    input  logic                   ce,
    output logic                   inst_sram_en,
    output logic [3:0]             inst_sram_wen,
    output logic [INST_ADDR_W-1:0] inst_sram_addr,
    output logic [31:0]            inst_sram_wdata,
    input  logic [31:0]            inst_sram_rdata,
    output logic [INST_ADDR_W-1:0] id_pc,
    output logic [31:0]            id_inst,
    output logic                   id_valid,
    output logic [EXC_W-1:0]       id_excepttype
);

    logic                   misaligned_s;
    logic [INST_ADDR_W-1:0] phys_addr_s;
    logic [EXC_W-1:0]       exc_load_s;
    logic [31:0]            id_inst_s;

    logic [INST_ADDR_W-1:0] id_pc_r;
    logic                   id_valid_r;
    logic [EXC_W-1:0]       exc_r;
    logic                   hold_valid_r;
    logic [31:0]            hold_inst_r;
    logic [1:0]             state_r;

    // Only the IF and ID stall bits matter here.
    logic unused_stall_s;
    assign unused_stall_s = ^{stall[5:3], stall[0]};

    assign misaligned_s = is_misaligned(pc);

    if_addr_map u_addr_map (
        .vaddr (pc),
        .paddr (phys_addr_s)
    );

    // A misaligned PC never reaches the SRAM; a stalled PC simply re-reads.
    assign inst_sram_en    = ce & ~flush & ~misaligned_s;
    assign inst_sram_addr  = phys_addr_s;
    assign inst_sram_wen   = 4'b0000;
    assign inst_sram_wdata = 32'h0000_0000;

    // Exception vector loaded with a new fetch: only the AdEL bit can be set.
    always_comb begin
        exc_load_s = 32'h0000_0000;
        exc_load_s[EXC_ADEL_BIT] = ce & misaligned_s;
    end

    // IF/ID boundary register plus hold buffer for decode stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_pc_r      <= RESET_PC;
            id_valid_r   <= 1'b0;
            exc_r        <= 32'h0000_0000;
            hold_valid_r <= 1'b0;
            hold_inst_r  <= 32'h0000_0000;
            state_r      <= ST_EMPTY;
        end else if (flush) begin
            id_pc_r      <= RESET_PC;
            id_valid_r   <= 1'b0;
            exc_r        <= 32'h0000_0000;
            hold_valid_r <= 1'b0;
            state_r      <= ST_EMPTY;
        end else if (stall[1] && !stall[2]) begin
            // IF stalled but decode advancing: hand decode a bubble.
            id_valid_r   <= 1'b0;
            exc_r        <= 32'h0000_0000;
            hold_valid_r <= 1'b0;
            state_r      <= ST_EMPTY;
        end else if (stall[1] && stall[2]) begin
            // Decode stalled: the SRAM output is only valid in the first
            // stalled cycle, so snapshot it before it moves on.
            case (state_r)
                ST_RUN: begin
                    hold_inst_r  <= inst_sram_rdata;
                    hold_valid_r <= 1'b1;
                    state_r      <= ST_HOLD;
                end
                ST_HOLD, ST_EMPTY: begin
                    state_r <= state_r;
                end
                default: begin
                    hold_valid_r <= 1'b0;
                    state_r      <= ST_EMPTY;
                end
            endcase
        end else begin
            id_pc_r      <= pc;
            id_valid_r   <= ce;
            exc_r        <= exc_load_s;
            hold_valid_r <= 1'b0;
            state_r      <= ce ? ST_RUN : ST_EMPTY;
        end
    end

    // The instruction word cannot be registered here: in RUN it is the SRAM
    // read data itself, which only becomes valid during the cycle after the
    // request. A faulting fetch never enabled the SRAM, so it shows a NOP.
    always_comb begin
        id_inst_s = NOP_INST;
        if (exc_r[EXC_ADEL_BIT]) begin
            id_inst_s = NOP_INST;
        end else begin
            case (state_r)
                ST_RUN:   id_inst_s = inst_sram_rdata;
                ST_HOLD:  id_inst_s = hold_valid_r ? hold_inst_r : NOP_INST;
                ST_EMPTY: id_inst_s = NOP_INST;
                default:  id_inst_s = NOP_INST;
            endcase
        end
    end

    assign id_pc         = id_pc_r;
    assign id_valid      = id_valid_r;
    assign id_excepttype = exc_r;
    assign id_inst       = id_inst_s;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: directed scenarios followed by a
// randomized phase checked against a transaction-level model of what decode
// should see after each clock edge.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;
    localparam logic [31:0] ADEL_VEC = 32'h0000_0010;

    logic        clk;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        ce;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;
    logic [31:0] id_excepttype;

    logic        model_on;
    logic [31:0] tb_rdata;
    logic [31:0] model_rdata;

    int checks;
    int errors;

    // Expected IF/ID contents in the random phase.
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic [31:0] exp_exc;

    if_fetch_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .pc              (pc),
        .ce              (ce),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .id_pc           (id_pc),
        .id_inst         (id_inst),
        .id_valid        (id_valid),
        .id_excepttype   (id_excepttype)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of the instruction memory at a physical address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9e37_79b1 + 32'h1234_5677;
    endfunction

    // kseg0 (0x8000_0000..0x9fff_ffff) and kseg1 (0xa000_0000..0xbfff_ffff)
    // are windows onto physical address 0; everything else is identity.
    function automatic logic [31:0] phys_of(input logic [31:0] v);
        if (v >= 32'h8000_0000 && v < 32'ha000_0000) return v - 32'h8000_0000;
        else if (v >= 32'ha000_0000 && v < 32'hc000_0000) return v - 32'ha000_0000;
        else return v;
    endfunction

    // Synchronous SRAM: returns the addressed word one cycle after an enabled
    // request, garbage otherwise.
    always @(posedge clk) begin
        model_rdata <= inst_sram_en ? mem_word(inst_sram_addr) : $urandom();
    end

    assign inst_sram_rdata = model_on ? model_rdata : tb_rdata;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic after_edge();
        @(posedge clk);
        #1;
    endtask

    // Advance the decode-visible model across one clock edge.
    task automatic model_edge();
        logic mis;
        mis = (pc % 4) != 0;
        if (flush) begin
            exp_valid = 1'b0; exp_pc = RESET_PC; exp_inst = 32'h0; exp_exc = 32'h0;
        end else if (stall[1] && !stall[2]) begin
            exp_valid = 1'b0; exp_inst = 32'h0; exp_exc = 32'h0;
        end else if (stall[1] && stall[2]) begin
            exp_valid = exp_valid;
        end else begin
            exp_pc    = pc;
            exp_valid = ce;
            exp_exc   = (ce && mis) ? ADEL_VEC : 32'h0;
            exp_inst  = (ce && !mis) ? mem_word(phys_of(pc)) : 32'h0;
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0; ce = 1'b0; pc = RESET_PC; stall = 6'b000000; flush = 1'b0;
        tb_rdata = 32'h0; model_on = 1'b0;
        exp_valid = 1'b0; exp_pc = RESET_PC; exp_inst = 32'h0; exp_exc = 32'h0;

        // Reset state.
        #12;
        check_eq("rst_valid", {31'd0, id_valid}, 32'd0);
        check_eq("rst_pc", id_pc, RESET_PC);
        check_eq("rst_inst", id_inst, 32'h0);
        check_eq("rst_exc", id_excepttype, 32'h0);
        check_eq("rst_en", {31'd0, inst_sram_en}, 32'd0);

        // 1: first fetch from the boot vector.
        @(negedge clk);
        rst = 1'b1; ce = 1'b1; pc = 32'hbfc0_0000;
        #1;
        check_eq("t1_addr", inst_sram_addr, 32'h1fc0_0000);
        check_eq("t1_en", {31'd0, inst_sram_en}, 32'd1);
        check_eq("t1_wen", {28'd0, inst_sram_wen}, 32'd0);
        check_eq("t1_wdata", inst_sram_wdata, 32'h0);
        after_edge();
        tb_rdata = 32'h2408_0001; pc = 32'hbfc0_0004; stall = 6'b000111;
        @(negedge clk);
        check_eq("t1_idpc", id_pc, 32'hbfc0_0000);
        check_eq("t1_inst", id_inst, 32'h2408_0001);
        check_eq("t1_valid", {31'd0, id_valid}, 32'd1);

        // 2: decode stall for three edges while SRAM data wanders.
        after_edge();
        tb_rdata = 32'h1111_1111;
        @(negedge clk);
        check_eq("t2_hold1", id_inst, 32'h2408_0001);
        check_eq("t2_en_rep", {31'd0, inst_sram_en}, 32'd1);
        after_edge();
        tb_rdata = 32'h2222_2222;
        @(negedge clk);
        check_eq("t2_hold2", id_inst, 32'h2408_0001);
        after_edge();
        tb_rdata = 32'h3333_3333; stall = 6'b000000;
        @(negedge clk);
        check_eq("t2_hold3", id_inst, 32'h2408_0001);
        check_eq("t2_holdpc", id_pc, 32'hbfc0_0000);
        after_edge();
        tb_rdata = 32'h2409_0002; pc = 32'hbfc0_0008; stall = 6'b000011;
        @(negedge clk);
        check_eq("t2_nextpc", id_pc, 32'hbfc0_0004);
        check_eq("t2_nextinst", id_inst, 32'h2409_0002);
        check_eq("t2_nextvalid", {31'd0, id_valid}, 32'd1);

        // 3: bubble, then resume with the held PC.
        after_edge();
        tb_rdata = 32'h9999_9999; stall = 6'b000000;
        @(negedge clk);
        check_eq("t3_bub_valid", {31'd0, id_valid}, 32'd0);
        check_eq("t3_bub_inst", id_inst, 32'h0);
        after_edge();
        tb_rdata = 32'h240a_0003; pc = 32'hbfc0_000c; stall = 6'b000111;
        @(negedge clk);
        check_eq("t3_res_pc", id_pc, 32'hbfc0_0008);
        check_eq("t3_res_inst", id_inst, 32'h240a_0003);
        check_eq("t3_res_valid", {31'd0, id_valid}, 32'd1);

        // 4: flush while holding.
        after_edge();
        tb_rdata = 32'h5555_5555; flush = 1'b1;
        @(negedge clk);
        check_eq("t4_hold", id_inst, 32'h240a_0003);
        check_eq("t4_flush_en", {31'd0, inst_sram_en}, 32'd0);
        after_edge();
        flush = 1'b0; stall = 6'b000000; pc = 32'hbfc0_0002;
        @(negedge clk);
        check_eq("t4_valid", {31'd0, id_valid}, 32'd0);
        check_eq("t4_inst", id_inst, 32'h0);
        check_eq("t4_exc", id_excepttype, 32'h0);
        check_eq("t4_pc", id_pc, RESET_PC);

        // 5: misaligned fetch.
        check_eq("t5_en", {31'd0, inst_sram_en}, 32'd0);
        after_edge();
        tb_rdata = 32'h7777_7777; pc = 32'hbfc0_0010;
        @(negedge clk);
        check_eq("t5_exc", id_excepttype, ADEL_VEC);
        check_eq("t5_valid", {31'd0, id_valid}, 32'd1);
        check_eq("t5_inst", id_inst, 32'h0);
        check_eq("t5_pc", id_pc, 32'hbfc0_0002);

        // 6: asynchronous reset in the middle of a RUN cycle.
        after_edge();
        tb_rdata = 32'h240b_0004;
        @(negedge clk);
        check_eq("t6_run_inst", id_inst, 32'h240b_0004);
        check_eq("t6_run_exc", id_excepttype, 32'h0);
        #2;
        rst = 1'b0; ce = 1'b0;
        #1;
        check_eq("t6_valid", {31'd0, id_valid}, 32'd0);
        check_eq("t6_pc", id_pc, RESET_PC);
        check_eq("t6_inst", id_inst, 32'h0);
        check_eq("t6_en", {31'd0, inst_sram_en}, 32'd0);

        // Randomized phase against the decode-visible model.
        @(negedge clk);
        rst = 1'b1; model_on = 1'b1; pc = RESET_PC;
        exp_valid = 1'b0; exp_pc = RESET_PC; exp_inst = 32'h0; exp_exc = 32'h0;
        @(posedge clk);
        model_edge();
        #1;
        for (int i = 0; i < 400; i++) begin
            int sel;
            logic [31:0] rp;
            ce    = ($urandom_range(0, 99) < 85);
            flush = ($urandom_range(0, 99) < 8);
            sel   = $urandom_range(0, 9);
            if (sel < 5)      stall = 6'b000000;
            else if (sel < 7) stall = 6'b000011;
            else if (sel < 9) stall = 6'b000111;
            else              stall = 6'b001111;
            rp = $urandom();
            rp[31:29] = 3'($urandom_range(0, 7));
            rp[1:0]   = ($urandom_range(0, 99) < 15) ? 2'($urandom_range(1, 3)) : 2'b00;
            pc = rp;
            @(negedge clk);
            check_eq("r_en", {31'd0, inst_sram_en},
                     {31'd0, ce && !flush && (pc % 4) == 0});
            check_eq("r_addr", inst_sram_addr, phys_of(pc));
            check_eq("r_valid", {31'd0, id_valid}, {31'd0, exp_valid});
            check_eq("r_pc", id_pc, exp_pc);
            check_eq("r_inst", id_inst, exp_inst);
            check_eq("r_exc", id_excepttype, exp_exc);
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the PC register.
- Takes the current fetch PC and its chip-enable, drives the instruction SRAM port, and translates kseg0/kseg1 addresses to physical.
- Flags misaligned fetches and registers PC and exception state into the IF/ID boundary.
- A hold buffer keeps the instruction presented to decode stable while decode is stalled, because the synchronous SRAM output does not hold its value during a stall.

Parameters:
- RESET_PC, 32'hbfc0_0000, PC value presented on id_pc while no valid instruction is held.
- EXC_ADEL_BIT, 4, bit of id_excepttype set for an instruction-fetch address error.
- NOP_INST, 32'h0000_0000, instruction word emitted for a bubble or after a flush.

Ports:
- clk  in  1  clock, all state on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  6  pipeline stall vector; bit0 = PC, bit1 = IF, bit2 = ID.
- flush  in  1  exception/eret flush; kills the IF/ID contents.
- pc  in  32  fetch PC from the PC stage.
- ce  in  1  PC valid; 0 = no fetch this cycle.
- inst_sram_en  out  1  SRAM read enable.
- inst_sram_wen  out  4  always 4'b0000.
- inst_sram_addr  out  32  physical fetch address.
- inst_sram_wdata  out  32  always 0.
- inst_sram_rdata  in  32  read data, valid one cycle after the request.
- id_pc  out  32  PC of the instruction in IF/ID.
- id_inst  out  32  instruction word to decode.
- id_valid  out  1  IF/ID holds a real instruction.
- id_excepttype  out  32  exception vector accompanying id_pc.

Behaviour:
- Request side (combinational):
  - inst_sram_en = ce & ~flush & (pc[1:0]==2'b00).
  - Address mapping: if pc[31:29] is 3'b100 or 3'b101, inst_sram_addr = {3'b000, pc[28:0]}; otherwise inst_sram_addr = pc.
  - The request repeats harmlessly while the PC stage is stalled.
- IF/ID register (rising clk edge, priority order):
  1. rst low (asynchronous): id_pc=RESET_PC, id_valid=0, exc_r=0, hold_valid=0, hold_inst=0, state=EMPTY.
  2. flush: id_valid=0, id_pc=RESET_PC, exc_r=0, hold_valid=0, state=EMPTY. Flush overrides any stall.
  3. stall[1] & ~stall[2]: insert a bubble (id_valid=0, exc_r=0, state=EMPTY).
  4. stall[1] & stall[2]: hold all registers.
  5. ~stall[1]: id_pc=pc, id_valid=ce, exc_r[EXC_ADEL_BIT]=ce & (pc[1:0]!=0), all other exc_r bits 0; state=RUN if ce, else EMPTY.
- State machine (2-bit: EMPTY, RUN, HOLD):
  - EMPTY: id_inst=NOP_INST.
  - RUN: id_inst=inst_sram_rdata. If stall[2] is sampled high, capture hold_inst<=inst_sram_rdata and go to HOLD.
  - HOLD: id_inst=hold_inst. Leave HOLD when stall[2] drops: go to RUN if a new instruction is loaded that edge, else EMPTY.
  - Flush from any state goes to EMPTY.
- Exception output and misaligned fetches:
  - id_excepttype = exc_r.
  - A misaligned fetch still reaches decode with id_valid=1 and the exception bit set, but its id_inst is forced to NOP_INST (the SRAM was not enabled).
- Latency: the instruction at pc in cycle t appears on id_inst/id_pc in cycle t+1 when unstalled.
- Reset mid-operation: every register clears immediately; no SRAM request is issued while rst is low, because ce is low.

Decomposition:
- Shared defines header (existing lib defines):
  - StallBus and InstAddrBus widths.
  - Exception bit index for fetch AdEL.
  - Segment-mapping constants 3'b100/3'b101.
  - NOP encoding.
- One sub-module is natural: if_addr_map, the combinational virtual-to-physical mapper, reused later by the data-memory stage.
- The hold buffer stays inline.

Test Plan:
1. Reset, then ce=1, pc=32'hbfc0_0000, no stall → inst_sram_addr=32'h1fc0_0000, inst_sram_en=1. Next cycle, with rdata=32'h2408_0001: id_pc=32'hbfc0_0000, id_inst=32'h2408_0001, id_valid=1.
2. Decode stall while rdata changes: stall=6'b000111 for 3 cycles while rdata moves 32'h1111_1111 → 32'h2222_2222 → 32'h3333_3333 → id_inst stays equal to the captured word. Release the stall → the next PC's data appears with no duplicate or lost instruction.
3. Bubble: stall=6'b000011 for 1 cycle → id_valid=0, id_inst=0. The following cycle resumes with the held PC.
4. Flush during HOLD: flush=1 with stall=6'b000111 → next edge id_valid=0, id_inst=0, id_excepttype=0.
5. Misaligned fetch: pc=32'hbfc0_0002, ce=1 → inst_sram_en=0. Next cycle id_excepttype=32'h0000_0010, id_valid=1, id_inst=0.
6. Asynchronous reset asserted mid-cycle during RUN → outputs clear before the next clk edge: id_valid=0, id_pc=32'hbfc0_0000.
